uart_hex_line_parser: RTL
=========================

Name: uart_hex_line_parser

Overview:
- Parametrised successor to the current UART hex-input front end.
- Consumes a byte stream, typically from the RX FIFO, with a valid/ready handshake.
- Assembles a CR-terminated line of ASCII hex digits into a value of up to DIGIT_COUNT nibbles. Supports backspace editing, case-insensitive digits, ignored characters, error classification, and a held result with acknowledge.
- Sits between the UART RX/FIFO pair and the main control FSM.

Parameters:
DIGIT_COUNT, 4, maximum hex digits per line; value width = 4*DIGIT_COUNT; legal 1..16
TERM_CHAR, 8'h0D, line terminator (CR)
IGNORE_CHAR, 8'h0A, byte accepted and dropped (LF); also drops 8'h20 space
CNT_W, $clog2(DIGIT_COUNT+1), width of the digit-count output

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_data  in  8  received ASCII byte
in_valid  in  1  in_data valid (FIFO not empty)
in_ready  out  1  byte consumed this cycle when in_valid&in_ready (drives FIFO pop)
out_value  out  4*DIGIT_COUNT  assembled value, right-aligned, zero-extended
out_digits  out  CNT_W  number of digits in out_value
out_err  out  2  0 = ok, 1 = invalid char, 2 = overflow, 3 = empty line
out_valid  out  1  result pending; held until acknowledged
out_ack  in  1  consumer acknowledge; clears out_valid
err_count  out  8  saturating count of lines ending with out_err != 0

Behaviour:
- Reset (reset=0, async) sets all state and outputs to 0; FSM goes to COLLECT. Release is synchronised internally with a 2-flop deassert.
- Accumulator acc[4*DIGIT_COUNT-1:0] and cnt[CNT_W-1:0] are internal; the output registers are separate, so the next line can assemble while a result is pending.
- in_ready = !out_valid || out_ack. Ready is low only while an unacknowledged result is held. Bytes never drop silently; the FIFO backs up.
- FSM states:
  - COLLECT: normal digit entry.
  - DISCARD: error seen; bytes are consumed and ignored until TERM_CHAR. The first error code is latched.
- Per accepted byte in COLLECT:
  - Digits '0'-'9', 'A'-'F' or 'a'-'f', with cnt<DIGIT_COUNT: acc <= {acc[4*DIGIT_COUNT-5:0], nib}; cnt+1. For DIGIT_COUNT=1, acc <= nib.
  - Digit with cnt==DIGIT_COUNT: latch err=2, go to DISCARD.
  - Backspace 8'h08 or 8'h7F: if cnt>0, acc <= acc>>4 and cnt-1; if cnt==0, no effect.
  - IGNORE_CHAR or 8'h20: no effect.
  - TERM_CHAR: go to the completion step.
  - Any other byte: latch err=1, go to DISCARD.
- In DISCARD, only TERM_CHAR has effect (completion); backspace does not clear the error.
- Completion on the TERM_CHAR accept edge:
  - out_value <= acc, out_digits <= cnt.
  - out_err <= latched error, else 3 if cnt==0, else 0.
  - out_valid <= 1 on the next edge, so result latency is 1 cycle after the CR accept.
  - acc, cnt and the latched error clear; state goes to COLLECT.
  - err_count increments if out_err != 0 and saturates at 255.
- Acknowledge: out_ack with out_valid clears out_valid on the next edge. out_ack without out_valid is ignored.
- Simultaneous out_ack and a CR accept in the same cycle: the new result loads and out_valid stays 1. The new value wins; no bubble.
- On an error line, out_value/out_digits show the digits gathered before the error; consumers must check out_err first.
- Reset mid-line discards the partial line; no result is emitted.

Test Plan:
1. Bytes "1","a","F","3",CR, out_ack held 1 -> out_valid pulses 1 cycle after CR; out_value=16'h1AF3, out_digits=4, out_err=0.
2. "1","2",8'h08,"7",LF,CR -> out_value=16'h0017, out_digits=2, out_err=0; LF consumed with no effect.
3. "12345",CR (DIGIT_COUNT=4) -> out_err=2, out_value=16'h1234, err_count=1; next line "9",CR -> 16'h0009, err 0.
4. "1G",CR then CR -> first result err=1 with value 16'h0001; second result err=3, digits=0; err_count=2.
5. Two lines back-to-back with out_ack=0 -> in_ready falls after the first CR; the second line bytes stay in the FIFO. Pulse out_ack -> second line completes, value correct, nothing lost.
6. Assert reset after "AB" -> all outputs 0 immediately (async). After release, "C",CR -> out_value=16'h000C.

Source files
------------

// File: rtl/uart_hex_line_parser.sv
// Assembles CR-terminated lines of ASCII hex digits from a valid/ready byte stream
// into a held result with an error code, digit count and saturating error counter.
module uart_hex_line_parser #(
    parameter int          DIGIT_COUNT = 4,
    parameter logic [7:0]  TERM_CHAR   = 8'h0D,
    parameter logic [7:0]  IGNORE_CHAR = 8'h0A,
    parameter int          CNT_W       = $clog2(DIGIT_COUNT + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [4*DIGIT_COUNT-1:0] out_value,
    output logic [CNT_W-1:0]         out_digits,
    output logic [1:0]               out_err,
    output logic                     out_valid,
    input  logic                     out_ack,
    output logic [7:0]               err_count
);

    localparam int              W         = 4 * DIGIT_COUNT;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(DIGIT_COUNT);
    localparam logic [1:0]      ERR_NONE  = 2'd0;
    localparam logic [1:0]      ERR_CHAR  = 2'd1;
    localparam logic [1:0]      ERR_OVF   = 2'd2;
    localparam logic [1:0]      ERR_EMPTY = 2'd3;

    typedef enum logic {COLLECT, DISCARD} state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       err_lat, err_nxt, line_err;
    logic [1:0]       rst_sync;
    logic             rst_n;
    logic             accept, complete;
    logic             is_hex, is_bs, is_skip, is_term;
    logic [3:0]       nib;

    // NOTE: reset asserts asynchronously but releases two edges later, so no flop
    // sees the deassertion near its own clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign in_ready = !out_valid || out_ack;
    assign accept   = in_valid && in_ready;

    always_comb begin
        nib    = 4'd0;
        is_hex = 1'b0;
        if (in_data >= 8'h30 && in_data <= 8'h39) begin
            nib    = in_data[3:0];
            is_hex = 1'b1;
        end else if ((in_data >= 8'h41 && in_data <= 8'h46) ||
                     (in_data >= 8'h61 && in_data <= 8'h66)) begin
            nib    = in_data[3:0] + 4'd9;
            is_hex = 1'b1;
        end
    end

    assign is_bs    = (in_data == 8'h08) || (in_data == 8'h7F);
    assign is_skip  = (in_data == IGNORE_CHAR) || (in_data == 8'h20);
    assign is_term  = (in_data == TERM_CHAR);
    assign line_err = (err_lat != ERR_NONE) ? err_lat :
                      (cnt == '0)           ? ERR_EMPTY : ERR_NONE;

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        err_nxt   = err_lat;
        complete  = 1'b0;
        if (accept) begin
            if (is_term) begin
                complete  = 1'b1;
                acc_nxt   = '0;
                cnt_nxt   = '0;
                err_nxt   = ERR_NONE;
                state_nxt = COLLECT;
            end else if (state == COLLECT) begin
                if (is_hex) begin
                    if (cnt < MAX_CNT) begin
                        acc_nxt = (acc << 4) | W'(nib);
                        cnt_nxt = cnt + CNT_W'(1);
                    end else begin
                        err_nxt   = ERR_OVF;
                        state_nxt = DISCARD;
                    end
                end else if (is_bs) begin
                    if (cnt != '0) begin
                        acc_nxt = acc >> 4;
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end else if (!is_skip) begin
                    err_nxt   = ERR_CHAR;
                    state_nxt = DISCARD;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COLLECT;
            acc     <= '0;
            cnt     <= '0;
            err_lat <= ERR_NONE;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            err_lat <= err_nxt;
        end
    end

    // Result registers are separate from the accumulator so a new line can
    // assemble while this one waits for acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_value  <= '0;
            out_digits <= '0;
            out_err    <= ERR_NONE;
            out_valid  <= 1'b0;
            err_count  <= 8'd0;
        end else if (complete) begin
            out_value  <= acc;
            out_digits <= cnt;
            out_err    <= line_err;
            out_valid  <= 1'b1;
            if (line_err != ERR_NONE && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end else if (out_ack) begin
            out_valid <= 1'b0;
        end
    end

endmodule
